// File: rtl/clk_ratio_meter_if.sv
// Interface bundling the measurement controls and results of clk_ratio_meter.
//   en        : measurement enable (driven by the user)
//   sig_in    : signal under measurement, may be asynchronous to clk
//   period    : last rising-to-rising period in clk cycles
//   high_time : clk cycles the synchronized signal was high within that period
//   pow2      : period is a power of two
//   div_log2  : log2(period) when pow2 is set, else 0
//   valid     : one-cycle pulse when the result fields update
//   timeout   : no edge before the counter saturated; sticky until next edge
// Modports: master = the meter, slave = the consumer/stimulus side.
interface clk_ratio_meter_if #(
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned LOG_W = $clog2(CNT_W);

  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             pow2;
  logic [LOG_W-1:0] div_log2;
  logic             valid;
  logic             timeout;

  modport master (
    input  en,
    input  sig_in,
    output period,
    output high_time,
    output pow2,
    output div_log2,
    output valid,
    output timeout
  );

  modport slave (
    output en,
    output sig_in,
    input  period,
    input  high_time,
    input  pow2,
    input  div_log2,
    input  valid,
    input  timeout
  );
endinterface

// File: rtl/clk_ratio_meter.sv
// Measures the period (rising edge to rising edge) and high time of a slow
// clock/strobe in clk cycles, flags power-of-two ratios and reports a
// timeout when edges stop arriving.
//   clk : single clock, all logic on posedge
//   rst : synchronous reset, active low
//   bus : clk_ratio_meter_if master modport (en, sig_in in; results out)
module clk_ratio_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  clk_ratio_meter_if.master  bus
);

  localparam int unsigned LOG_W = $clog2(CNT_W);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  // One below saturation: the step into all-ones is the timeout step.
  localparam logic [CNT_W-1:0] CntLast = {{(CNT_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {StIdle, StArm, StMeas, StTout} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s;
  logic                   edge_det;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             pow2_q, pow2_d;
  logic [LOG_W-1:0] log2_q, log2_d;
  logic             valid_q, valid_d;
  logic             tout_q, tout_d;

  logic             cnt_pow2;
  logic [LOG_W-1:0] cnt_log2;

  // sync_q[0] takes the raw input; the last stage is the clk-domain copy.
  assign s        = sync_q[SYNC_STAGES-1];
  assign edge_det = s & ~prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
      prev_q <= s;
    end
  end

  // Power-of-two test on the running count; log2 is only kept when pow2.
  always_comb begin
    cnt_pow2 = (cnt_q != '0) && ((cnt_q & (cnt_q - CntOne)) == '0);
    cnt_log2 = '0;
    for (int unsigned i = 0; i < CNT_W; i++) begin
      if (cnt_q[i]) begin
        cnt_log2 = LOG_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    pow2_d   = pow2_q;
    log2_d   = log2_q;
    valid_d  = 1'b0;
    tout_d   = tout_q;

    if (!bus.en) begin
      // Disable wins over any simultaneous edge; results are held.
      state_d = StIdle;
      cnt_d   = '0;
      hcnt_d  = '0;
      tout_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StArm;
        end
        StArm: begin
          if (edge_det) begin
            cnt_d   = CntOne;
            hcnt_d  = CntOne;
            state_d = StMeas;
          end
        end
        StMeas: begin
          if (edge_det) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            pow2_d   = cnt_pow2;
            log2_d   = cnt_pow2 ? cnt_log2 : '0;
            valid_d  = 1'b1;
            cnt_d    = CntOne;
            hcnt_d   = CntOne;
          end else begin
            cnt_d = cnt_q + CntOne;
            if (s) begin
              hcnt_d = hcnt_q + CntOne;
            end
            if (cnt_q == CntLast) begin
              tout_d  = 1'b1;
              state_d = StTout;
            end
          end
        end
        StTout: begin
          // Start of the span is unknown, so this edge only re-anchors.
          if (edge_det) begin
            tout_d  = 1'b0;
            cnt_d   = CntOne;
            hcnt_d  = CntOne;
            state_d = StMeas;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      pow2_q   <= 1'b0;
      log2_q   <= '0;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      pow2_q   <= pow2_d;
      log2_q   <= log2_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_q;
  assign bus.pow2      = pow2_q;
  assign bus.div_log2  = log2_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = tout_q;

endmodule
